tcp_msg_req_poll_sched: RTL and testbench



---
 rtl/tcp_msg_sched_pkg.sv | 21 ++
 rtl/tcp_msg_active_bitvec.sv | 70 +++++++
 rtl/tcp_msg_req_poll_sched.sv | 126 ++++++++++++
 tb/tb_tcp_msg_req_poll_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_msg_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_msg_sched_pkg
//  Description : Shared types for the TCP message-request poll scheduler.
//                Holds the scheduler FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tcp_msg_sched_pkg;

    localparam int SCHED_STATE_W = 3;

    typedef enum logic [SCHED_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_CHK    = 3'd1,
        ST_WR_MEM = 3'd2,
        ST_ENQ    = 3'd3,
        ST_RESP   = 3'd4
    } sched_state_e;

endpackage : tcp_msg_sched_pkg
`default_nettype wire

// File: rtl/tcp_msg_active_bitvec.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_msg_active_bitvec
//  Description : One poll-active bit per flow plus a population count.
//                The lookup sees the bitvector after any same-cycle clear, so
//                a flow cleared by the poller in the lookup cycle reads as
//                inactive. When set and clear hit in the same cycle the clear
//                applies first and the set wins.
//  Ports       : clk, rst            clock / async active-high reset
//                set_val_i/flowid_i  set the active bit of a flow
//                clr_val_i/flowid_i  clear the active bit of a flow
//                lookup_flowid_i     flow to examine
//                lookup_hit_o        active bit of lookup flow (clear bypassed)
//                active_cnt_o        number of set bits
//  Revision    : 1.0 - initial release
// ============================================================================
module tcp_msg_active_bitvec #(
    parameter int FLOWID_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_val_i,
    input  logic [FLOWID_W-1:0] set_flowid_i,
    input  logic                clr_val_i,
    input  logic [FLOWID_W-1:0] clr_flowid_i,
    input  logic [FLOWID_W-1:0] lookup_flowid_i,
    output logic                lookup_hit_o,
    output logic [FLOWID_W:0]   active_cnt_o
);

    localparam int              NUM_FLOWS = 1 << FLOWID_W;
    localparam logic [FLOWID_W:0] CNT_ONE = 1;

    logic [NUM_FLOWS-1:0] bits_q, bits_d;
    logic [FLOWID_W:0]    cnt_q,  cnt_d;
    logic                 eff_clr;

    // A clear only counts when it actually turns a 1 into a 0.
    assign eff_clr      = clr_val_i & bits_q[clr_flowid_i];
    assign lookup_hit_o = bits_q[lookup_flowid_i] &
                          ~(clr_val_i && (clr_flowid_i == lookup_flowid_i));
    assign active_cnt_o = cnt_q;

    always_comb begin
        bits_d = bits_q;
        if (clr_val_i) bits_d[clr_flowid_i] = 1'b0;
        if (set_val_i) bits_d[set_flowid_i] = 1'b1;

        // Set is only issued for a bit that reads 0 after bypass, so a
        // simultaneous effective clear always nets to zero.
        cnt_d = cnt_q;
        case ({set_val_i, eff_clr})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q <= '0;
            cnt_q  <= '0;
        end else begin
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule : tcp_msg_active_bitvec
`default_nettype wire

// File: rtl/tcp_msg_req_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_msg_req_poll_sched
//  Description : Front end of the TCP message-request poller. Accepts an app
//                request, rejects it if the flow is already poll-active,
//                otherwise writes it to msg-req mem, then enqueues the flowid.
//                Sole writer of the msg-req queue; poller requeues have
//                fixed priority over our own enqueue.
//  Ports       : app_sched_req_* / sched_app_req_rdy   request in
//                sched_app_resp_* / app_sched_resp_rdy response out
//                sched_msg_req_mem_wr_* / ..._wr_rdy    mem write
//                sched_msg_req_q_wr_* / ..._wr_rdy      queue write
//                poll_sched_requeue_* / sched_poll_requeue_rdy
//                poll_active_bitvec_clear_req_*        active bit clear
//                sched_active_cnt                      active flow count
//  Revision    : 1.0 - initial release
// ============================================================================
module tcp_msg_req_poll_sched
    import tcp_msg_sched_pkg::*;
#(
    parameter int FLOWID_W   = 8,
    parameter int REQ_DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  app_sched_req_val,
    input  logic [FLOWID_W-1:0]   app_sched_req_flowid,
    input  logic [REQ_DATA_W-1:0] app_sched_req_data,
    output logic                  sched_app_req_rdy,
    output logic                  sched_app_resp_val,
    output logic                  sched_app_resp_accepted,
    input  logic                  app_sched_resp_rdy,
    output logic                  sched_msg_req_mem_wr_val,
    output logic [FLOWID_W-1:0]   sched_msg_req_mem_wr_addr,
    output logic [REQ_DATA_W-1:0] sched_msg_req_mem_wr_data,
    input  logic                  msg_req_mem_sched_wr_rdy,
    output logic                  sched_msg_req_q_wr_val,
    output logic [FLOWID_W-1:0]   sched_msg_req_q_wr_data,
    input  logic                  msg_req_q_sched_wr_rdy,
    input  logic                  poll_sched_requeue_val,
    input  logic [FLOWID_W-1:0]   poll_sched_requeue_flowid,
    output logic                  sched_poll_requeue_rdy,
    input  logic                  poll_active_bitvec_clear_req_val,
    input  logic [FLOWID_W-1:0]   poll_active_bitvec_clear_req_flowid,
    output logic [FLOWID_W:0]     sched_active_cnt
);

    sched_state_e          state_q, state_d;
    logic [FLOWID_W-1:0]   flowid_q;
    logic [REQ_DATA_W-1:0] data_q;
    logic                  accepted_q;
    logic                  chk_hit;
    logic                  chk_set;

    assign chk_set = (state_q == ST_CHK) & ~chk_hit;

    tcp_msg_active_bitvec #(
        .FLOWID_W (FLOWID_W)
    ) u_active_bitvec (
        .clk             (clk),
        .rst             (rst),
        .set_val_i       (chk_set),
        .set_flowid_i    (flowid_q),
        .clr_val_i       (poll_active_bitvec_clear_req_val),
        .clr_flowid_i    (poll_active_bitvec_clear_req_flowid),
        .lookup_flowid_i (flowid_q),
        .lookup_hit_o    (chk_hit),
        .active_cnt_o    (sched_active_cnt)
    );

    // State register and request latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            flowid_q   <= '0;
            data_q     <= '0;
            accepted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && app_sched_req_val) begin
                flowid_q <= app_sched_req_flowid;
                data_q   <= app_sched_req_data;
            end
            if (state_q == ST_CHK) begin
                accepted_q <= ~chk_hit;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (app_sched_req_val)        state_d = ST_CHK;
            ST_CHK:    state_d = chk_hit ? ST_RESP : ST_WR_MEM;
            ST_WR_MEM: if (msg_req_mem_sched_wr_rdy) state_d = ST_ENQ;
            // Requeue owns the queue port whenever it is valid.
            ST_ENQ:    if (!poll_sched_requeue_val && msg_req_q_sched_wr_rdy)
                           state_d = ST_RESP;
            ST_RESP:   if (app_sched_resp_rdy)       state_d = ST_IDLE;
            default:   state_d = sched_state_e'(3'bxxx);
        endcase
    end

    // Outputs. Request ready is masked by reset so nothing is offered
    // while the block is held in reset.
    always_comb begin
        sched_app_req_rdy         = (state_q == ST_IDLE) & ~rst;
        sched_app_resp_val        = (state_q == ST_RESP);
        sched_app_resp_accepted   = accepted_q;
        sched_msg_req_mem_wr_val  = (state_q == ST_WR_MEM);
        sched_msg_req_mem_wr_addr = flowid_q;
        sched_msg_req_mem_wr_data = data_q;
        if (poll_sched_requeue_val) begin
            sched_msg_req_q_wr_val  = 1'b1;
            sched_msg_req_q_wr_data = poll_sched_requeue_flowid;
            sched_poll_requeue_rdy  = msg_req_q_sched_wr_rdy;
        end else begin
            sched_msg_req_q_wr_val  = (state_q == ST_ENQ);
            sched_msg_req_q_wr_data = flowid_q;
            sched_poll_requeue_rdy  = 1'b0;
        end
    end

endmodule : tcp_msg_req_poll_sched
`default_nettype wire

// File: tb/tb_tcp_msg_req_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tcp_msg_req_poll_sched
//  Description : Directed scoreboard bench for tcp_msg_req_poll_sched.
//                Stimulus pushes expected mem writes, queue writes and
//                responses; a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcp_msg_req_poll_sched;

    localparam int FW = 8;
    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic          req_val;
    logic [FW-1:0] req_flowid;
    logic [DW-1:0] req_data;
    logic          req_rdy;
    logic          resp_val;
    logic          resp_acc;
    logic          resp_rdy;
    logic          mem_val;
    logic [FW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_rdy;
    logic          q_val;
    logic [FW-1:0] q_data;
    logic          q_rdy;
    logic          rq_val;
    logic [FW-1:0] rq_flowid;
    logic          rq_rdy;
    logic          clr_val;
    logic [FW-1:0] clr_flowid;
    logic [FW:0]   cnt;

    tcp_msg_req_poll_sched #(.FLOWID_W(FW), .REQ_DATA_W(DW)) dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .app_sched_req_val                   (req_val),
        .app_sched_req_flowid                (req_flowid),
        .app_sched_req_data                  (req_data),
        .sched_app_req_rdy                   (req_rdy),
        .sched_app_resp_val                  (resp_val),
        .sched_app_resp_accepted             (resp_acc),
        .app_sched_resp_rdy                  (resp_rdy),
        .sched_msg_req_mem_wr_val            (mem_val),
        .sched_msg_req_mem_wr_addr           (mem_addr),
        .sched_msg_req_mem_wr_data           (mem_data),
        .msg_req_mem_sched_wr_rdy            (mem_rdy),
        .sched_msg_req_q_wr_val              (q_val),
        .sched_msg_req_q_wr_data             (q_data),
        .msg_req_q_sched_wr_rdy              (q_rdy),
        .poll_sched_requeue_val              (rq_val),
        .poll_sched_requeue_flowid           (rq_flowid),
        .sched_poll_requeue_rdy              (rq_rdy),
        .poll_active_bitvec_clear_req_val    (clr_val),
        .poll_active_bitvec_clear_req_flowid (clr_flowid),
        .sched_active_cnt                    (cnt)
    );

    typedef struct { logic [FW-1:0] addr; logic [DW-1:0] data; } mem_t;
    typedef struct { logic [FW-1:0] flow; bit sched; }            qent_t;
    typedef struct { bit acc; int lat; }                          resp_t;

    mem_t  exp_mem[$];
    qent_t exp_q[$];
    resp_t exp_resp[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_cyc     = 0;
    int mem_done    = 0;
    int sched_done  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: output seen with nothing expected (t=%0t)", name, $time);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        mem_t  me;
        qent_t qe;
        resp_t re;
        if (!rst) begin
            if (req_val && req_rdy) acc_cyc = cyc;
            if (mem_val && mem_rdy) begin
                if (exp_mem.size() == 0) unexpected("mem_wr");
                else begin
                    me = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, me.addr);
                    chk("mem_data", mem_data, me.data);
                end
                mem_done++;
            end
            if (q_val && q_rdy) begin
                if (exp_q.size() == 0) unexpected("q_wr");
                else begin
                    qe = exp_q.pop_front();
                    chk("q_data", q_data, qe.flow);
                    if (qe.sched) begin
                        chk("enq_after_mem", mem_done, sched_done + 1);
                        sched_done++;
                    end
                end
            end
            if (rq_val) chk("requeue_rdy", rq_rdy, q_rdy);
            if (resp_val && resp_rdy) begin
                if (exp_resp.size() == 0) unexpected("resp");
                else begin
                    re = exp_resp.pop_front();
                    chk("resp_accepted", resp_acc, re.acc);
                    chk("resp_latency", cyc - acc_cyc, re.lat);
                end
            end
        end
    end

    task automatic send_req(input logic [FW-1:0] f, input logic [DW-1:0] d);
        int n = 0;
        req_val    = 1'b1;
        req_flowid = f;
        req_data   = d;
        @(negedge clk);
        while (!req_rdy && n < 50) begin @(negedge clk); n++; end
        if (!req_rdy) unexpected("req_rdy_timeout");
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_resp.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (exp_resp.size() != 0) begin
            unexpected("resp_timeout");
            exp_resp.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_mem_val();
        int n = 0;
        @(negedge clk);
        while (!mem_val && n < 50) begin @(negedge clk); n++; end
        if (!mem_val) unexpected("mem_val_timeout");
    endtask

    task automatic push_acc(input logic [FW-1:0] f, input logic [DW-1:0] d, input int lat);
        exp_mem.push_back('{addr: f, data: d});
        exp_q.push_back('{flow: f, sched: 1'b1});
        exp_resp.push_back('{acc: 1'b1, lat: lat});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_val = 0; req_flowid = 0; req_data = 0;
        resp_rdy = 1; mem_rdy = 1; q_rdy = 1;
        rq_val = 0; rq_flowid = 0; clr_val = 0; clr_flowid = 0;

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_req_rdy",  req_rdy,  0);
        chk("rst_mem_val",  mem_val,  0);
        chk("rst_q_val",    q_val,    0);
        chk("rst_resp_val", resp_val, 0);
        chk("rst_rq_rdy",   rq_rdy,   0);
        chk("rst_cnt",      cnt,      0);
        rst = 1'b0; #1;
        chk("idle_req_rdy", req_rdy, 1);

        // Fresh request on flow 5
        @(posedge clk); #1;
        push_acc(8'd5, 64'hAB, 4);
        send_req(8'd5, 64'hAB);
        wait_done();
        chk("cnt_after_first", cnt, 1);

        // Same flow again: rejected, no mem/queue write
        exp_resp.push_back('{acc: 1'b0, lat: 2});
        send_req(8'd5, 64'h11);
        wait_done();
        chk("cnt_after_reject", cnt, 1);

        // Clear of flow 5 lands in the CHK cycle of a new flow-5 request
        push_acc(8'd5, 64'hCD, 4);
        send_req(8'd5, 64'hCD);
        clr_val = 1'b1; clr_flowid = 8'd5;
        @(posedge clk); #1;
        clr_val = 1'b0;
        wait_done();
        chk("cnt_after_bypass", cnt, 1);

        // Clear of an inactive flow is a no-op; clear of flow 5 drops count
        clr_val = 1'b1; clr_flowid = 8'd200;
        @(posedge clk); #1;
        chk("cnt_clr_inactive", cnt, 1);
        clr_flowid = 8'd5;
        @(posedge clk); #1;
        clr_val = 1'b0;
        chk("cnt_clr_active", cnt, 0);

        // Requeue of flow 9 held 3 cycles while in ENQ
        exp_mem.push_back('{addr: 8'd7, data: 64'h77});
        exp_q.push_back('{flow: 8'd9, sched: 1'b0});
        exp_q.push_back('{flow: 8'd9, sched: 1'b0});
        exp_q.push_back('{flow: 8'd9, sched: 1'b0});
        exp_q.push_back('{flow: 8'd7, sched: 1'b1});
        exp_resp.push_back('{acc: 1'b1, lat: 7});
        send_req(8'd7, 64'h77);
        wait_mem_val();
        @(posedge clk); #1;
        rq_val = 1'b1; rq_flowid = 8'd9;
        repeat (3) @(posedge clk); #1;
        rq_val = 1'b0;
        wait_done();
        chk("cnt_after_requeue", cnt, 1);

        // Mem write ready held low for 5 cycles
        mem_rdy = 1'b0;
        push_acc(8'd3, 64'h3333, 8);
        send_req(8'd3, 64'h3333);
        repeat (5) @(posedge clk); #1;
        mem_rdy = 1'b1;
        wait_done();
        chk("cnt_after_mem_stall", cnt, 2);

        // Reset while stalled in WR_MEM: request discarded
        mem_rdy = 1'b0;
        send_req(8'd11, 64'hBAD);
        wait_mem_val();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_mem_val",  mem_val,  0);
        chk("midrst_req_rdy",  req_rdy,  0);
        chk("midrst_q_val",    q_val,    0);
        chk("midrst_resp_val", resp_val, 0);
        chk("midrst_cnt",      cnt,      0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0; mem_rdy = 1'b1; #1;
        chk("postrst_req_rdy", req_rdy, 1);
        repeat (3) @(posedge clk); #1;

        // Next request after reset is processed normally
        push_acc(8'd11, 64'h1111, 4);
        send_req(8'd11, 64'h1111);
        wait_done();
        chk("cnt_after_rst_req", cnt, 1);

        // Flow 5 was wiped by reset, so it is accepted again
        push_acc(8'd5, 64'h55, 4);
        send_req(8'd5, 64'h55);
        wait_done();
        chk("cnt_final", cnt, 2);

        repeat (10) @(posedge clk); #1;
        chk("mem_leftover",  exp_mem.size(),  0);
        chk("q_leftover",    exp_q.size(),    0);
        chk("resp_leftover", exp_resp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_tcp_msg_req_poll_sched
`default_nettype wire
